// File: rtl/adder_reservation_station_pkg.sv
// Shared widths, opcode encodings, instruction field positions and small
// decode/CDB helpers for the adder reservation station.
package adder_reservation_station_pkg;

  localparam int WORD_SIZE = 32;
  localparam int REG_INDEX = 5;
  localparam int RB_SIZE   = 8;
  localparam int RB_INDEX  = 4;
  localparam int RB_SEL    = $clog2(RB_SIZE);
  localparam int FU_INDEX  = 4;
  localparam int OP_W      = 4;
  localparam int IMM_W     = 13;

  localparam logic [RB_INDEX-1:0] READY = 4'b1111;

  localparam int OP_LSB  = 28;
  localparam int RD_LSB  = 23;
  localparam int RS_LSB  = 18;
  localparam int RT_LSB  = 13;
  localparam int IMM_LSB = 0;

  localparam logic [OP_W-1:0] INST_ADD  = 4'h0;
  localparam logic [OP_W-1:0] INST_SUB  = 4'h1;
  localparam logic [OP_W-1:0] INST_ADDI = 4'h2;
  localparam logic [OP_W-1:0] INST_SUBI = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } rs_state_e;

  function automatic logic [OP_W-1:0] inst_op(input logic [WORD_SIZE-1:0] inst);
    return inst[OP_LSB +: OP_W];
  endfunction

  function automatic logic [REG_INDEX-1:0] inst_rs(input logic [WORD_SIZE-1:0] inst);
    return inst[RS_LSB +: REG_INDEX];
  endfunction

  function automatic logic [REG_INDEX-1:0] inst_rt(input logic [WORD_SIZE-1:0] inst);
    return inst[RT_LSB +: REG_INDEX];
  endfunction

  function automatic logic [WORD_SIZE-1:0] inst_imm_sext(input logic [WORD_SIZE-1:0] inst);
    return {{(WORD_SIZE-IMM_W){inst[IMM_LSB+IMM_W-1]}}, inst[IMM_LSB +: IMM_W]};
  endfunction

  // Tags outside the ROB range (READY included) never match a CDB slot.
  function automatic logic cdb_hit(input logic [RB_INDEX-1:0] tag,
                                   input logic [RB_SIZE-1:0]  valid);
    return (tag != READY) && (tag[RB_INDEX-1:RB_SEL] == '0) && valid[tag[RB_SEL-1:0]];
  endfunction

  function automatic logic [WORD_SIZE-1:0] cdb_word(input logic [RB_INDEX-1:0]          tag,
                                                    input logic [RB_SIZE*WORD_SIZE-1:0] data);
    return data[int'(tag[RB_SEL-1:0])*WORD_SIZE +: WORD_SIZE];
  endfunction

  function automatic logic [WORD_SIZE-1:0] alu_result(input logic [OP_W-1:0]      op,
                                                      input logic [WORD_SIZE-1:0] j,
                                                      input logic [WORD_SIZE-1:0] k);
    logic [WORD_SIZE-1:0] r;
    r = '0;
    case (op)
      INST_ADD, INST_ADDI: r = j + k;
      INST_SUB, INST_SUBI: r = j - k;
      default:             r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/adder_reservation_station_if.sv
// Issue, register-lookup, CDB snoop and result signals between the ROB side
// (master) and the adder reservation station (slave).
interface adder_reservation_station_if;
  import adder_reservation_station_pkg::*;

  logic [FU_INDEX-1:0]          issue_fu;
  logic [WORD_SIZE-1:0]         issue_inst;
  logic [RB_INDEX-1:0]          issue_rbindex;
  logic [REG_INDEX-1:0]         src_j;
  logic [REG_INDEX-1:0]         src_k;
  logic [WORD_SIZE-1:0]         vj;
  logic [WORD_SIZE-1:0]         vk;
  logic [RB_INDEX-1:0]          qj;
  logic [RB_INDEX-1:0]          qk;
  logic [RB_SIZE*WORD_SIZE-1:0] cdb_data;
  logic [RB_SIZE-1:0]           cdb_valid;
  logic                         busy;
  logic                         result_valid;
  logic [WORD_SIZE-1:0]         result_data;
  logic [RB_INDEX-1:0]          result_rbindex;

  modport master (
    output issue_fu, issue_inst, issue_rbindex, vj, vk, qj, qk, cdb_data, cdb_valid,
    input  src_j, src_k, busy, result_valid, result_data, result_rbindex
  );

  modport slave (
    input  issue_fu, issue_inst, issue_rbindex, vj, vk, qj, qk, cdb_data, cdb_valid,
    output src_j, src_k, busy, result_valid, result_data, result_rbindex
  );

endinterface

// File: rtl/adder_reservation_station_operand_snooper.sv
// One source operand: holds value and producer tag, captures from the CDB either
// at issue (same-edge bypass) or while the station waits.
module adder_reservation_station_operand_snooper
  import adder_reservation_station_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         load,
  input  logic                         snoop_en,
  input  logic [WORD_SIZE-1:0]         v_in,
  input  logic [RB_INDEX-1:0]          q_in,
  input  logic [RB_SIZE*WORD_SIZE-1:0] cdb_data,
  input  logic [RB_SIZE-1:0]           cdb_valid,
  output logic [WORD_SIZE-1:0]         value,
  output logic                         ready,
  output logic                         ready_next
);

  logic [WORD_SIZE-1:0] value_q, value_d;
  logic [RB_INDEX-1:0]  tag_q, tag_d;

  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    if (load) begin
      value_d = v_in;
      tag_d   = q_in;
      if (cdb_hit(q_in, cdb_valid)) begin
        value_d = cdb_word(q_in, cdb_data);
        tag_d   = READY;
      end
    end else if (snoop_en && cdb_hit(tag_q, cdb_valid)) begin
      value_d = cdb_word(tag_q, cdb_data);
      tag_d   = READY;
    end
  end

  always_ff @(posedge clk or posedge reset or posedge flush) begin
    if (reset || flush) begin
      value_q <= '0;
      tag_q   <= READY;
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

  assign value      = value_q;
  assign ready      = (tag_q == READY);
  assign ready_next = (tag_d == READY);

endmodule

// File: rtl/adder_reservation_station.sv
// Single-entry reservation station with integer adder; returns the result
// tagged with its ROB index for one cycle.
//
//   state | meaning
//   IDLE  | empty, accepts an issue when issue_fu matches FU_ID
//   WAIT  | holding instruction, snooping CDB for unresolved operand tags
//   EXEC  | operands ready, latency down-counter running
//   DONE  | result_valid high for exactly one cycle
module adder_reservation_station
  import adder_reservation_station_pkg::*;
#(
  parameter int FU_ID       = 0,
  parameter int ADD_LATENCY = 2
) (
  input logic                        clk,
  input logic                        reset,
  input logic                        flush,
  adder_reservation_station_if.slave rs_if
);

  localparam int              CNT_W    = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LATENCY - 1);

  rs_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic [RB_INDEX-1:0]  rbindex_q, rbindex_d;
  logic                 result_valid_q, result_valid_d;
  logic [WORD_SIZE-1:0] result_data_q, result_data_d;
  logic [RB_INDEX-1:0]  result_rbindex_q, result_rbindex_d;

  logic                 issue_hit, load, snoop_en, imm_op;
  logic [OP_W-1:0]      issue_op;
  logic [WORD_SIZE-1:0] vk_in, j_value, k_value;
  logic [RB_INDEX-1:0]  qk_in;
  logic                 j_ready, k_ready, j_ready_next, k_ready_next;

  assign issue_op  = inst_op(rs_if.issue_inst);
  assign issue_hit = (rs_if.issue_fu == FU_INDEX'(FU_ID));
  assign load      = (state_q == ST_IDLE) && issue_hit;
  assign snoop_en  = (state_q == ST_WAIT);
  assign imm_op    = (issue_op == INST_ADDI) || (issue_op == INST_SUBI);

  // Immediate forms replace the k operand with sext(imm), already resolved.
  assign vk_in = imm_op ? inst_imm_sext(rs_if.issue_inst) : rs_if.vk;
  assign qk_in = imm_op ? READY : rs_if.qk;

  assign rs_if.src_j = inst_rs(rs_if.issue_inst);
  assign rs_if.src_k = inst_rt(rs_if.issue_inst);

  // Combinational so the ROB sees busy within the presentation cycle.
  assign rs_if.busy           = (state_q != ST_IDLE) || issue_hit;
  assign rs_if.result_valid   = result_valid_q;
  assign rs_if.result_data    = result_data_q;
  assign rs_if.result_rbindex = result_rbindex_q;

  adder_reservation_station_operand_snooper u_snoop_j (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .load       (load),
    .snoop_en   (snoop_en),
    .v_in       (rs_if.vj),
    .q_in       (rs_if.qj),
    .cdb_data   (rs_if.cdb_data),
    .cdb_valid  (rs_if.cdb_valid),
    .value      (j_value),
    .ready      (j_ready),
    .ready_next (j_ready_next)
  );

  adder_reservation_station_operand_snooper u_snoop_k (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .load       (load),
    .snoop_en   (snoop_en),
    .v_in       (vk_in),
    .q_in       (qk_in),
    .cdb_data   (rs_if.cdb_data),
    .cdb_valid  (rs_if.cdb_valid),
    .value      (k_value),
    .ready      (k_ready),
    .ready_next (k_ready_next)
  );

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    op_d             = op_q;
    rbindex_d        = rbindex_q;
    result_valid_d   = 1'b0;
    result_data_d    = result_data_q;
    result_rbindex_d = result_rbindex_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_hit) begin
          op_d      = issue_op;
          rbindex_d = rs_if.issue_rbindex;
          cnt_d     = CNT_LOAD;
          state_d   = (j_ready_next && k_ready_next) ? ST_EXEC : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Uses registered readiness: a capture this edge moves us on next edge.
        if (j_ready && k_ready) begin
          cnt_d   = CNT_LOAD;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          result_valid_d   = 1'b1;
          result_data_d    = alu_result(op_q, j_value, k_value);
          result_rbindex_d = rbindex_q;
          state_d          = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset or posedge flush) begin
    if (reset || flush) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      op_q             <= '0;
      rbindex_q        <= '0;
      result_valid_q   <= 1'b0;
      result_data_q    <= '0;
      result_rbindex_q <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      op_q             <= op_d;
      rbindex_q        <= rbindex_d;
      result_valid_q   <= result_valid_d;
      result_data_q    <= result_data_d;
      result_rbindex_q <= result_rbindex_d;
    end
  end

endmodule

// File: doc/adder_reservation_station.md
Name: adder_reservation_station

Overview:
- Single-entry reservation station plus integer adder for one ADD/SUB/ADDI/SUBI functional-unit slot.
- Sits downstream of the reorder buffer's issue port (issue_fu/issue_inst/issue_rbindex) and the register status file.
- Snoops the per-ROB-entry data bus until both operands are ready, executes, then returns the result, tagged with its ROB index, to the CDB arbiter that fills the reorder buffer's data/valid slots.

Parameters:
- WORD_SIZE, 32, datapath and instruction width
- REG_INDEX, 5, register-number width
- RB_SIZE, 8, reorder-buffer entries (CDB slots)
- RB_INDEX, 4, ROB tag width (one bit wider than log2(RB_SIZE))
- READY, 4'b1111, tag meaning "value is in register file"
- FU_ID, 0, this unit's functional-unit number
- FU_INDEX, 4, functional-unit number width
- ADD_LATENCY, 2, cycles spent in EXEC (must be >= 1)

Ports:
- clk  in  1  clock
- reset  in  1  global reset
- flush  in  1  this unit's bit of the ROB reset_out vector; treated as an additional asynchronous clear
- issue_fu  in  FU_INDEX  unit targeted by the ROB this cycle
- issue_inst  in  WORD_SIZE  instruction word
- issue_rbindex  in  RB_INDEX  ROB tag of the instruction
- src_j, src_k  out  REG_INDEX  combinational register numbers for status/register lookup (rs, rt of issue_inst)
- vj, vk  in  WORD_SIZE  register values for src_j/src_k
- qj, qk  in  RB_INDEX  producer tags for src_j/src_k
- cdb_data  in  RB_SIZE*WORD_SIZE  per-entry result bus (entry n at bits n*WORD_SIZE+:WORD_SIZE)
- cdb_valid  in  RB_SIZE  per-entry valid
- busy  out  1  unit occupied or being issued to
- result_valid  out  1  result present this cycle
- result_data  out  WORD_SIZE  result value
- result_rbindex  out  RB_INDEX  ROB tag of result

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk. reset or flush high clears state to IDLE, result_valid=0, result_data=0, result_rbindex=0, all operand tags to READY. Flush has priority over every other event.
- Instruction fields:
  - op = [31:28], encodings from the shared parameter file
  - rd = [27:23], rs = [22:18], rt = [17:13]
  - imm = [12:0], sign-extended to WORD_SIZE
- busy = (state != IDLE) | (issue_fu == FU_ID). It is combinational so the ROB never double-issues within the presentation cycle.
- States IDLE, WAIT, EXEC, DONE:
  - IDLE: at a posedge with issue_fu==FU_ID, latch inst/op/rbindex, vj/qj, vk/qk.
    - For ADDI/SUBI, take the k operand as sext(imm) with qk=READY.
    - Same-edge bypass: if a captured tag != READY and cdb_valid[tag]=1, take cdb_data[tag] and set the tag to READY.
    - Go to EXEC if both tags are READY after bypass, else WAIT.
  - WAIT: each posedge, for each non-READY tag with cdb_valid[tag]=1, load the data and set the tag READY. Both tags may resolve in the same cycle, including from the same entry. Go to EXEC once both are READY (takes effect on the following edge's evaluation).
  - EXEC: a counter loads ADD_LATENCY-1 on entry and decrements each cycle. When it reaches 0, compute at that edge and go to DONE.
    - ADD/ADDI: result = j + k.
    - SUB/SUBI: result = j - k.
    - Arithmetic is modulo 2^WORD_SIZE; there is no overflow flag.
    - Any other opcode yields 0.
  - DONE: result_valid=1, result_data and result_rbindex stable for exactly one cycle, then IDLE. busy falls in the same edge unless a new issue is presented.
- Status-file timing contract: the ROB asserts the issue-side status write in the same cycle it presents issue_fu. The status file commits at the edge that ends that cycle. This station samples qj/qk at that same edge, so it sees the pre-instruction mapping (rd==rs is safe).
- Issue while not IDLE is a protocol violation. It is ignored, and the bench flags it.
- Flush mid-WAIT or mid-EXEC discards the instruction; no result_valid is produced.
- Tags >= RB_SIZE other than READY are never snooped.

Decomposition:
- Shared package/parameters file holds:
  - opcode constants INST_ADD, INST_SUB, INST_ADDI, INST_SUBI
  - READY, WORD_SIZE, REG_INDEX, RB_SIZE, RB_INDEX, FU_INDEX
  - instruction field positions
- One sub-module, operand_snooper: one instance per operand. Holds value/tag and performs the bypass/WAIT capture from cdb_data/cdb_valid.

Test Plan:
- Issue ADD rd=3, rs=1, rt=2 with qj=qk=READY, vj=5, vk=7, ADD_LATENCY=2 → busy immediately; result_valid pulses 3 cycles after capture with data=12 and the issue tag; busy low the next cycle.
- Issue SUBI with vj=3, imm=13'h1FFF (−1) → result 4. Issue SUB with vj=0, vk=1 → 32'hFFFFFFFF.
- Issue with qj=5 (vk ready); cdb_valid[5] rises with 100 four cycles later → station stays in WAIT until then; result = 100+vk, ADD_LATENCY cycles later.
- qj=qk=2, cdb_valid[2] asserted at the capture edge with data 9 → bypass, no WAIT; ADD result 18.
- Flush pulse during EXEC → busy and result_valid stay 0. Immediate re-issue is accepted and completes normally.
- Assert reset during WAIT → all outputs 0 and busy 0 asynchronously. A later cdb_valid on the old tag produces no result.
